// File: rtl/counter_mod.sv
// Parametrised up/down counter with a programmable inclusive upper bound, parallel load,
// wrap/saturate mode, a registered terminal-count pulse and a sticky overflow flag.
module counter_mod #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] CNT_RESET = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ZERO  = '0;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_count_next;
    logic             w_bound;
    logic             w_ovf_next;

    always_comb begin
        w_count_next = r_count;
        w_bound      = 1'b0;
        if (load) begin
            w_count_next = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (up) begin
                // A count already above a freshly lowered bound also wraps/saturates here.
                if (r_count >= max_val) begin
                    w_bound      = 1'b1;
                    w_count_next = sat ? max_val : CNT_ZERO;
                end else begin
                    w_count_next = r_count + CNT_ONE;
                end
            end else begin
                if (r_count > max_val) begin
                    w_count_next = max_val;
                end else if (r_count == CNT_ZERO) begin
                    w_bound      = 1'b1;
                    w_count_next = sat ? CNT_ZERO : max_val;
                end else begin
                    w_count_next = r_count - CNT_ONE;
                end
            end
        end
    end

    // A bound event on the same edge as clr_ovf keeps the flag set.
    always_comb begin
        w_ovf_next = r_ovf;
        if (load) begin
            w_ovf_next = 1'b0;
        end else if (w_bound) begin
            w_ovf_next = 1'b1;
        end else if (clr_ovf) begin
            w_ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= CNT_RESET;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_tc    <= w_bound;
            r_ovf   <= w_ovf_next;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the counting rules.
module tb_counter_mod;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       sat;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] max_val;
    logic       clr_ovf;
    logic [7:0] count;
    logic       tc;
    logic       ovf;

    int checks;
    int errors;

    // reference model state
    int m_count;
    bit m_tc;
    bit m_ovf;

    counter_mod #(.WIDTH(8), .RESET_VAL(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_count = 0;
        m_tc    = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge();
        int mx;
        int nxt;
        bit bnd;
        mx  = int'(max_val);
        nxt = m_count;
        bnd = 1'b0;
        if (load) begin
            m_count = (int'(load_val) < mx) ? int'(load_val) : mx;
            m_tc    = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (en) begin
                if (up) begin
                    nxt = m_count + 1;
                    if (nxt > mx) begin
                        bnd = 1'b1;
                        nxt = sat ? mx : 0;
                    end
                end else if (m_count > mx) begin
                    nxt = mx;
                end else if (m_count == 0) begin
                    bnd = 1'b1;
                    nxt = sat ? 0 : mx;
                end else begin
                    nxt = m_count - 1;
                end
            end
            m_count = nxt;
            m_tc    = bnd;
            if (bnd) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    endtask

    // advance one edge; inputs are stable across it, outputs observed 1ns later
    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        $display("t=%0t en=%0b up=%0b sat=%0b load=%0b lv=%0d max=%0d clr=%0b -> count=%0d tc=%0b ovf=%0b",
                 $time, en, up, sat, load, load_val, max_val, clr_ovf, count, tc, ovf);
    endtask

    task automatic idle_inputs();
        en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; clr_ovf = 1'b0;
        load_val = 8'd0;
    endtask

    task automatic do_load(input logic [7:0] v, input logic [7:0] mx);
        idle_inputs();
        load = 1'b1; load_val = v; max_val = mx;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (count !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d tc=%0b ovf=%0b, required 0/0/0", count, tc, ovf);
        end
        reset = 1'b0;
        model_reset();
        max_val = 8'd255; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (count !== 8'd5) begin
            errors++;
            $display("FAIL reset_precount: count=%0d, required 5", count);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (count !== 8'd0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: count=%0d tc=%0b, required 0/0 before next edge", count, tc);
        end
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (count !== 8'(i) || count !== 8'(m_count)) begin
                errors++;
                $display("FAIL reset_resume%0d: count=%0d, required %0d", i, count, i);
            end
        end
    endtask

    task automatic test_wrap_up();
        do_load(8'd0, 8'd9);
        en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (count !== 8'(i % 10) || tc !== (i == 10) || ovf !== (i >= 10)) begin
                errors++;
                $display("FAIL wrap_up step%0d: count=%0d tc=%0b ovf=%0b, required %0d/%0b/%0b",
                         i, count, tc, ovf, i % 10, i == 10, i >= 10);
            end
        end
    endtask

    task automatic test_wrap_down();
        int exp_w [3] = '{0, 9, 8};
        bit tcw   [3] = '{0, 1, 0};
        int exp_s [3] = '{0, 0, 0};
        bit tcs   [3] = '{0, 1, 1};
        do_load(8'd1, 8'd9);
        en = 1'b1; up = 1'b0; sat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 8'(exp_w[i]) || tc !== tcw[i]) begin
                errors++;
                $display("FAIL wrap_down step%0d: count=%0d tc=%0b, required %0d/%0b",
                         i, count, tc, exp_w[i], tcw[i]);
            end
        end
        do_load(8'd1, 8'd9);
        en = 1'b1; up = 1'b0; sat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 8'(exp_s[i]) || tc !== tcs[i]) begin
                errors++;
                $display("FAIL sat_down step%0d: count=%0d tc=%0b, required %0d/%0b",
                         i, count, tc, exp_s[i], tcs[i]);
            end
        end
    endtask

    task automatic test_load_clamp();
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL load_pre_ovf: ovf=%0b, required 1", ovf);
        end
        idle_inputs();
        load = 1'b1; en = 1'b1; up = 1'b1; load_val = 8'd200; max_val = 8'd50;
        tick();
        checks++;
        if (count !== 8'd50 || tc !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp: count=%0d tc=%0b ovf=%0b, required 50/0/0", count, tc, ovf);
        end
        load = 1'b0;
        tick();
        checks++;
        if (count !== 8'd0 || tc !== 1'b1) begin
            errors++;
            $display("FAIL load_then_wrap: count=%0d tc=%0b, required 0/1", count, tc);
        end
    endtask

    task automatic test_lowered_bound();
        do_load(8'd40, 8'd255);
        max_val = 8'd10; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (count !== 8'd0 || tc !== 1'b1) begin
            errors++;
            $display("FAIL lowered_up: count=%0d tc=%0b, required 0/1", count, tc);
        end
        do_load(8'd40, 8'd255);
        max_val = 8'd10; en = 1'b1; up = 1'b0;
        tick();
        checks++;
        if (count !== 8'd10 || tc !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL lowered_down: count=%0d tc=%0b ovf=%0b, required 10/0/0", count, tc, ovf);
        end
    endtask

    task automatic test_ovf_race();
        do_load(8'd9, 8'd9);
        en = 1'b1; up = 1'b1; sat = 1'b0; clr_ovf = 1'b1;
        tick();
        checks++;
        if (count !== 8'd0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_race: count=%0d ovf=%0b, required 0/1", count, ovf);
        end
        en = 1'b0;
        tick();
        checks++;
        if (count !== 8'd0 || ovf !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: count=%0d ovf=%0b tc=%0b, required 0/0/0", count, ovf, tc);
        end
        clr_ovf = 1'b0;
    endtask

    task automatic test_max_zero();
        do_load(8'd7, 8'd0);
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; up = 1'($urandom); sat = 1'($urandom);
            tick();
            checks++;
            if (count !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
                errors++;
                $display("FAIL max_zero step%0d: count=%0d tc=%0b ovf=%0b, required 0/1/1",
                         i, count, tc, ovf);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom);
            sat      = ($urandom_range(0, 3) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = 8'($urandom);
            clr_ovf  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0:       max_val = 8'd255;
                1:       max_val = 8'd0;
                2:       max_val = 8'($urandom);
                default: if ($urandom_range(0, 15) == 0) max_val = 8'($urandom_range(0, 15));
            endcase
            tick();
            checks++;
            if (count !== 8'(m_count) || tc !== m_tc || ovf !== m_ovf) begin
                errors++;
                $display("FAIL random%0d: count=%0d tc=%0b ovf=%0b, required %0d/%0b/%0b",
                         i, count, tc, ovf, m_count, m_tc, m_ovf);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        max_val = 8'd0;
        idle_inputs();
        model_reset();
        #12;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_load_clamp();
        test_lowered_bound();
        test_ovf_race();
        test_max_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised up/down counter with a programmable terminal value, parallel load, enable, and a wrap/saturate mode. It generalises the team's free-running 3-bit counter into a reusable timing and sequencing primitive. Typical uses on the board are clock-tick dividers, LED and display scan indices, and event counters. It reports a registered terminal-count pulse and a sticky overflow flag for downstream logic.

## Interface
- WIDTH, 8: counter width in bits, 2..32.
- RESET_VAL, 0: value of `count` after reset; must be ≤ 2^WIDTH-1.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- en  in  1  count enable; one step per clk while high.
- up  in  1  direction: 1 counts up, 0 counts down.
- sat  in  1  mode: 0 wraps at the bounds, 1 saturates (holds) at the bounds.
- load  in  1  synchronous parallel load; has priority over `en`.
- load_val  in  WIDTH  value to load.
- max_val  in  WIDTH  upper bound, inclusive. The counting range is 0..max_val.
- clr_ovf  in  1  synchronous clear of `ovf`.
- count  out  WIDTH  current count, registered.
- tc  out  1  registered one-cycle pulse on a bound event.
- ovf  out  1  sticky overflow/underflow flag, registered.

## Operation
- Reset, asynchronous, highest priority:
  - `count` = RESET_VAL, `tc` = 0, `ovf` = 0.
  - The outputs change without waiting for clk.
- Per-edge priority: reset > load > en > hold.
- Load:
  - `count` ← min(load_val, max_val).
  - `tc` = 0 and `ovf` ← 0 in the same edge.
- Enabled, up = 1:
  - count < max_val: count + 1.
  - count ≥ max_val, sat = 0: count ← 0. This is a bound event.
  - count ≥ max_val, sat = 1: count ← max_val. This is a bound event.
- Enabled, up = 0:
  - 0 < count ≤ max_val: count − 1.
  - count > max_val: count ← max_val. This happens only after max_val is lowered; it is not a bound event.
  - count = 0, sat = 0: count ← max_val. This is a bound event.
  - count = 0, sat = 1: count stays 0. This is a bound event.
- Bound event:
  - `tc` = 1 for exactly the cycle following the edge.
  - `ovf` ← 1 and stays high until clr_ovf, load, or reset.
  - In saturate mode, each enabled cycle spent at the bound is a new bound event, so `tc` stays high while holding.
- Simultaneous bound event and clr_ovf on one edge: the set wins, so `ovf` = 1.
- en = 0 and load = 0:
  - `count` holds.
  - `tc` = 0.
  - `ovf` holds; clr_ovf still clears it.
- max_val = 0:
  - `count` stays 0.
  - Every enabled cycle is a bound event.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - No internal carry is visible.
  - max_val = 2^WIDTH−1 gives a full-range counter.
- `up`, `sat` and `max_val` may change on any cycle. They take effect at the next edge.

## Timing
- All outputs are registered. No combinational path runs from the inputs to the outputs.
- Load latency: 1 cycle. `count` shows the loaded value after the load edge.
- Step latency: 1 cycle per enabled edge. A modulus-(M+1) count therefore repeats every M+1 enabled cycles.
- `tc` aligns with the cycle in which `count` first shows the post-bound value (0, max_val, or the held bound).
- Reset deassertion: counting resumes on the first edge where reset is sampled low. The block does not synchronise reset; that is the board top's responsibility.
- Reset mid-count or mid-load: any in-progress step is abandoned, and all outputs take their reset values.

## Test plan
- Reset mid-count:
  - Setup: WIDTH=8, RESET_VAL=0. Count to 5, then assert reset between edges.
  - Required: `count` = 0 and `tc` = 0 before the next edge. After release, the first two enabled edges give 1, then 2.
- Wrap up:
  - Setup: max_val=9, up=1, sat=0, en=1 from 0.
  - Required: sequence 0..9, 0, 1. `tc` is high only in the cycle `count` = 0 after the 9. `ovf` = 1 from then on.
- Wrap down, then saturate down:
  - Setup: up=0, sat=0, max_val=9, starting from 1.
  - Required: sequence 1, 0, 9, 8. `tc` pulses once, with `count` = 9.
  - Repeat with sat=1. Required: 1, 0, 0, 0, with `tc` held high while at 0.
- Load priority and clamp:
  - Setup: load=1 and en=1 together, load_val=200, max_val=50.
  - Required: `count` = 50, `tc` = 0, `ovf` cleared. On the next enabled up edge, `count` = 0 and `tc` = 1.
- Lowered bound:
  - Setup: `count` = 40, then max_val changed to 10.
  - Required: up gives 0 with `tc`. Down gives 10 without `tc`.
- ovf set/clear race:
  - Setup: clr_ovf asserted on the same edge as a wrap.
  - Required: `ovf` = 1. clr_ovf alone on a later edge gives `ovf` = 0.
